alu_rr_arbiter: RTL

Shares one alu_4bit datapath between two requesters using a round-robin arbiter with a valid/ready handshake on each request port. The block latches the winning operands and opcode, drives the ALU for one cycle, and registers the result and zero flag. It returns them on a single response channel tagged with the requester ID. It sits between two control agents and the combinational ALU, and also keeps a count of completed operations.

---
 rtl/alu_rr_arbiter_pkg.sv | 24 ++
 rtl/alu_4bit.sv | 29 ++
 rtl/alu_rr_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the round-robin ALU arbiter: opcodes and FSM states.
package alu_rr_arbiter_pkg;

  // Datapath width of the shared ALU
  localparam int ALU_W = 4;

  // ALU opcodes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU shared between the two requesters.
module alu_4bit
  import alu_rr_arbiter_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       op,
  output logic [ALU_W-1:0] result,
  output logic             zero_flag
);

  // Opcode decode; add/sub wrap, shifts move by one and fill with zero
  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = {a[ALU_W-2:0], 1'b0};
      OP_SHR: result = {1'b0, a[ALU_W-1:1]};
      OP_EQ:  result = (a == b) ? 4'd1 : 4'd0;
      default: result = '0;
    endcase
    zero_flag = (result == '0);
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one alu_4bit between two valid/ready requesters,
// with a registered, ID-tagged response channel and a completion counter.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic [CNT_W-1:0]  op_count,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              grant_id;
  logic              handshake;
  logic              resp_done;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [2:0]        opnd_op;
  logic              opnd_id;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  // Pick the winner: a lone requester wins, contention goes to whoever did not win last
  always_comb begin
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
    handshake = (state == IDLE) && (req0_valid || req1_valid) && !rst;
    resp_done = (state == RESP) && resp_valid && resp_ready;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> EXEC on accept, one ALU cycle, then wait for the consumer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: ready only for the granted requester while idle
  always_comb begin
    req0_ready = handshake && !grant_id;
    req1_ready = handshake && grant_id;
    busy       = (state != IDLE);
  end

  // Capture the winning request and remember who won for the next contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_a     <= '0;
      opnd_b     <= '0;
      opnd_op    <= '0;
      opnd_id    <= 1'b0;
      last_grant <= 1'b1;
    end else if (handshake) begin
      opnd_a     <= grant_id ? req1_a  : req0_a;
      opnd_b     <= grant_id ? req1_b  : req0_b;
      opnd_op    <= grant_id ? req1_op : req0_op;
      opnd_id    <= grant_id;
      last_grant <= grant_id;
    end
  end

  alu_4bit u_alu (
    .a         (opnd_a),
    .b         (opnd_b),
    .op        (opnd_op),
    .result    (alu_result),
    .zero_flag (alu_zero)
  );

  // Register the ALU output at the end of EXEC and hold it until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else if (state == EXEC) begin
      resp_valid  <= 1'b1;
      resp_id     <= opnd_id;
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
    end else if (resp_done) begin
      resp_valid  <= 1'b0;
    end
  end

  // Count completed responses, wrapping naturally at the counter width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (resp_done) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule
